// File: rtl/notch_coef_ctrl.sv
// Coefficient bank and commit sequencer for the cascaded notch filter chain.
// A double-buffered bank is swapped on a sample boundary, followed by a filter-state clear and a bypass settle window.
module notch_coef_ctrl #(
  parameter int WIDTH          = 16,
  parameter int NUM_STAGES     = 2,
  parameter int SETTLE_SAMPLES = 4,
  parameter logic [NUM_STAGES*5*WIDTH-1:0] COEF_RST = {
    16'h3c38, 16'hc1ec, 16'h4000, 16'hc000, 16'h4000,
    16'h3c38, 16'h6473, 16'h4000, 16'h678e, 16'h4000}
) (
  input  logic                          CLK,
  input  logic                          rst,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [3:0]                    cfg_stage,
  input  logic [2:0]                    cfg_sel,
  input  logic [WIDTH-1:0]              cfg_data,
  output logic                          cfg_err,
  input  logic                          commit_req,
  output logic                          commit_ack,
  input  logic                          sample_en,
  output logic                          filt_enable,
  output logic                          stage_clr,
  output logic                          bypass,
  output logic [NUM_STAGES*5*WIDTH-1:0] coef_out,
  output logic                          busy
);

  localparam int NW    = NUM_STAGES * 5;
  localparam int BW    = NW * WIDTH;
  localparam int CNT_W = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, COMMIT_WAIT, SWAP, SETTLE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [BW-1:0]    shadow;
  logic             wr_acc, addr_ok, settle_last;
  int               wr_idx;

  assign wr_acc      = cfg_valid && (state == IDLE);
  assign addr_ok     = (32'(cfg_stage) < NUM_STAGES) && (cfg_sel <= 3'd4);
  assign wr_idx      = 32'(cfg_stage) * 5 + 32'(cfg_sel);
  assign settle_last = sample_en && (cnt == CNT_W'(SETTLE_SAMPLES - 1));

  always_ff @(posedge CLK) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        if (commit_req) state_nx = COMMIT_WAIT;
      COMMIT_WAIT: if (sample_en)  state_nx = SWAP;
      SWAP:        state_nx = (SETTLE_SAMPLES > 0) ? SETTLE : IDLE;
      SETTLE:      if (settle_last) state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end

  // The strobe landing in SWAP is deliberately neither passed to the filters nor counted.
  always_comb begin
    cfg_ready   = (state == IDLE);
    busy        = (state != IDLE);
    filt_enable = sample_en && !rst && (state != SWAP);
  end

  // Registered flags are derived from the next state so they line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (rst) begin
      cnt        <= '0;
      cfg_err    <= 1'b0;
      commit_ack <= 1'b0;
      stage_clr  <= 1'b0;
      bypass     <= 1'b0;
    end else begin
      cfg_err    <= wr_acc && !addr_ok;
      commit_ack <= ((state == SWAP) || (state == SETTLE)) && (state_nx == IDLE);
      stage_clr  <= (state_nx == SWAP);
      bypass     <= (state_nx == SWAP) || (state_nx == SETTLE);
      if ((state == SETTLE) && sample_en)
        cnt <= settle_last ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      shadow   <= COEF_RST;
      coef_out <= COEF_RST;
    end else begin
      if (wr_acc && addr_ok) begin
        for (int w = 0; w < NW; w++)
          if (wr_idx == w) shadow[w*WIDTH +: WIDTH] <= cfg_data;
      end
      if (state == SWAP) coef_out <= shadow;
    end
  end

endmodule

// File: tb/tb_notch_coef_ctrl.sv
// Directed bench for notch_coef_ctrl: a default build and a build with no settle phase.
module tb_notch_coef_ctrl;

  localparam int W  = 16;
  localparam int BW = 2 * 5 * W;
  localparam logic [BW-1:0] RST = {
    16'h3c38, 16'hc1ec, 16'h4000, 16'hc000, 16'h4000,
    16'h3c38, 16'h6473, 16'h4000, 16'h678e, 16'h4000};

  logic CLK = 1'b0;
  logic rst;
  always #5 CLK = ~CLK;

  logic          cfg_valid, cfg_ready, cfg_err, commit_req, commit_ack;
  logic [3:0]    cfg_stage;
  logic [2:0]    cfg_sel;
  logic [W-1:0]  cfg_data;
  logic          sample_en, filt_enable, stage_clr, bypass, busy;
  logic [BW-1:0] coef_out;

  logic          z_cfg_valid, z_cfg_ready, z_cfg_err, z_commit_req, z_commit_ack;
  logic [3:0]    z_cfg_stage;
  logic [2:0]    z_cfg_sel;
  logic [W-1:0]  z_cfg_data;
  logic          z_sample_en, z_filt_enable, z_stage_clr, z_bypass, z_busy;
  logic [BW-1:0] z_coef_out;

  notch_coef_ctrl #(.WIDTH(W), .NUM_STAGES(2), .SETTLE_SAMPLES(4)) dut (
    .CLK(CLK), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_stage(cfg_stage), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .commit_req(commit_req), .commit_ack(commit_ack), .sample_en(sample_en),
    .filt_enable(filt_enable), .stage_clr(stage_clr), .bypass(bypass),
    .coef_out(coef_out), .busy(busy));

  notch_coef_ctrl #(.WIDTH(W), .NUM_STAGES(2), .SETTLE_SAMPLES(0)) dut_z (
    .CLK(CLK), .rst(rst), .cfg_valid(z_cfg_valid), .cfg_ready(z_cfg_ready),
    .cfg_stage(z_cfg_stage), .cfg_sel(z_cfg_sel), .cfg_data(z_cfg_data), .cfg_err(z_cfg_err),
    .commit_req(z_commit_req), .commit_ack(z_commit_ack), .sample_en(z_sample_en),
    .filt_enable(z_filt_enable), .stage_clr(z_stage_clr), .bypass(z_bypass),
    .coef_out(z_coef_out), .busy(z_busy));

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_coef;

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chkv(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic write(input logic [3:0] st, input logic [2:0] sel, input logic [W-1:0] d);
    cfg_valid = 1'b1; cfg_stage = st; cfg_sel = sel; cfg_data = d;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cfg_valid = 0; cfg_stage = 0; cfg_sel = 0; cfg_data = 0; commit_req = 0; sample_en = 0;
    z_cfg_valid = 0; z_cfg_stage = 0; z_cfg_sel = 0; z_cfg_data = 0; z_commit_req = 0; z_sample_en = 0;
    step();
    step();
    chkv("rst_coef", coef_out, RST);
    chk("rst_ready", cfg_ready, 1'b1);
    chk("rst_bypass", bypass, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", commit_ack, 1'b0);
    chk("rst_clr", stage_clr, 1'b0);
    sample_en = 1'b1; #1;
    chk("rst_fen_low", filt_enable, 1'b0);
    rst = 1'b0; #1;
    chk("idle_fen_on", filt_enable, 1'b1);
    sample_en = 1'b0; #1;
    chk("idle_fen_off", filt_enable, 1'b0);

    // Shadow write, no commit: active bank stays at reset values over 10 samples.
    write(4'd1, 3'd3, 16'hc200);
    chk("legal_no_err", cfg_err, 1'b0);
    for (int i = 0; i < 10; i++) begin
      sample_en = 1'b1; step(); sample_en = 1'b0; step();
    end
    chkv("no_commit_coef", coef_out, RST);

    // Commit; a write while busy must be refused and never applied.
    commit_req = 1'b1; step(); commit_req = 1'b0;
    chk("cw_busy", busy, 1'b1);
    chk("cw_ready", cfg_ready, 1'b0);
    chk("cw_bypass", bypass, 1'b0);
    write(4'd0, 3'd0, 16'h1234);
    step();
    chkv("cw_coef_old", coef_out, RST);
    sample_en = 1'b1; #1;
    chk("cw_fen", filt_enable, 1'b1);
    step();
    chk("swap_clr", stage_clr, 1'b1);
    chk("swap_bypass", bypass, 1'b1);
    chkv("swap_coef_old", coef_out, RST);
    chk("swap_fen", filt_enable, 1'b0);
    step();
    sample_en = 1'b0;
    exp_coef = RST;
    exp_coef[8*W +: W] = 16'hc200;
    chk("settle_clr_off", stage_clr, 1'b0);
    chk("settle_bypass", bypass, 1'b1);
    chkv("settle_coef_new", coef_out, exp_coef);
    chk("settle_ready", cfg_ready, 1'b0);
    write(4'd0, 3'd1, 16'h5555);
    for (int k = 1; k <= 4; k++) begin
      sample_en = 1'b1; step(); sample_en = 1'b0;
      if (k < 4) begin
        chk("settle_no_ack", commit_ack, 1'b0);
        chk("settle_hold_bypass", bypass, 1'b1);
        step(); step(); step();
      end
    end
    chk("ack_pulse", commit_ack, 1'b1);
    chk("ack_bypass_off", bypass, 1'b0);
    chk("ack_idle", busy, 1'b0);
    step();
    chk("ack_one_cycle", commit_ack, 1'b0);
    chkv("busy_writes_dropped", coef_out, exp_coef);

    // Illegal addresses: error pulse, shadow untouched.
    write(4'd2, 3'd0, 16'hffff);
    chk("err_stage", cfg_err, 1'b1);
    step();
    chk("err_stage_clear", cfg_err, 1'b0);
    write(4'd0, 3'd5, 16'heeee);
    chk("err_sel", cfg_err, 1'b1);
    step();
    chk("err_sel_clear", cfg_err, 1'b0);

    // Write coincident with commit_req is part of the commit.
    cfg_valid = 1'b1; cfg_stage = 4'd0; cfg_sel = 3'd2; cfg_data = 16'h7abc; commit_req = 1'b1;
    step();
    cfg_valid = 1'b0; commit_req = 1'b0;
    chk("cw2_busy", busy, 1'b1);
    sample_en = 1'b1; step(); sample_en = 1'b0;
    step();
    exp_coef[2*W +: W] = 16'h7abc;
    chkv("same_cycle_write", coef_out, exp_coef);

    // Reset during SETTLE aborts the commit.
    sample_en = 1'b1; step(); sample_en = 1'b0;
    chk("settle2_bypass", bypass, 1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("abort_bypass", bypass, 1'b0);
    chk("abort_ack", commit_ack, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chkv("abort_coef", coef_out, RST);
    step();
    chk("abort_no_late_ack", commit_ack, 1'b0);

    // No-settle build: SWAP goes straight back to IDLE.
    z_cfg_valid = 1'b1; z_cfg_stage = 4'd1; z_cfg_sel = 3'd4; z_cfg_data = 16'h1111;
    step();
    z_cfg_valid = 1'b0;
    z_commit_req = 1'b1; step(); z_commit_req = 1'b0;
    chk("z_busy", z_busy, 1'b1);
    z_sample_en = 1'b1; step(); z_sample_en = 1'b0;
    chk("z_swap_clr", z_stage_clr, 1'b1);
    chk("z_swap_bypass", z_bypass, 1'b1);
    chk("z_swap_no_ack", z_commit_ack, 1'b0);
    step();
    exp_coef = RST;
    exp_coef[9*W +: W] = 16'h1111;
    chk("z_ack", z_commit_ack, 1'b1);
    chk("z_bypass_off", z_bypass, 1'b0);
    chk("z_clr_off", z_stage_clr, 1'b0);
    chk("z_idle", z_busy, 1'b0);
    chkv("z_coef_new", z_coef_out, exp_coef);
    step();
    chk("z_ack_one_cycle", z_commit_ack, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/notch_coef_ctrl.md
Name: notch_coef_ctrl

Overview:
Configuration and sequencing controller for the cascaded IIR notch filter chain (NUM_STAGES biquad sections).
- Holds a writable shadow bank and an active bank of biquad coefficients (b0, b1, b2, a1, a2 per stage).
- Swaps shadow into active only on a sample boundary, then clears the filter state.
- Forces bypass for a programmable number of samples while the cleared filters settle.
- Sits between the register/config interface and the Notch_Filter instances; drives their coefficient inputs, enable, and state clear.

Parameters:
WIDTH, 16, coefficient and sample word width (coefficients S16.14).
NUM_STAGES, 2, number of cascaded biquad sections; legal range 1..16.
SETTLE_SAMPLES, 4, sample strobes with bypass held after a swap; 0 means no settle phase.
COEF_RST, {16'h3c38,16'hc1ec,16'h4000,16'hc000,16'h4000, 16'h3c38,16'h6473,16'h4000,16'h678e,16'h4000}, reset contents of both banks, NUM_STAGES*5*WIDTH bits, LSB word = stage0 b0.

Ports:
CLK  in  1  single clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
cfg_valid  in  1  coefficient write request.
cfg_ready  out  1  write accepted when cfg_valid & cfg_ready.
cfg_stage  in  4  target stage index.
cfg_sel  in  3  coefficient select: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
cfg_data  in  WIDTH  coefficient value.
cfg_err  out  1  one-cycle pulse: accepted write had an illegal address.
commit_req  in  1  request shadow→active swap; sampled only in IDLE.
commit_ack  out  1  one-cycle pulse: commit sequence complete.
sample_en  in  1  one-cycle strobe per new input sample x_n.
filt_enable  out  1  enable to the filter chain.
stage_clr  out  1  one-cycle filter-state clear.
bypass  out  1  output mux selects raw x_n instead of the filtered output.
coef_out  out  NUM_STAGES*5*WIDTH  active bank; stage s, coef k at bits [(s*5+k)*WIDTH +: WIDTH].
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; shadow and active banks = COEF_RST; settle counter = 0.
  - cfg_ready=1, cfg_err=0, commit_ack=0, stage_clr=0, bypass=0, busy=0.
  - filt_enable=0 while rst is high.
  - Reset mid-commit aborts the sequence with no ack; the active bank returns to COEF_RST.
- Writes:
  - Accepted only in IDLE (cfg_ready = state==IDLE).
  - A write updates the shadow word on the accepting edge. The active bank is unaffected until commit.
  - cfg_stage >= NUM_STAGES or cfg_sel > 4: no update; cfg_err=1 in the following cycle.
  - In other states cfg_ready=0 and cfg_valid is ignored; it is not queued.
- Coefficients are opaque: no arithmetic or saturation; any WIDTH-bit value is legal.
- filt_enable = sample_en in IDLE, COMMIT_WAIT and SETTLE; 0 in SWAP.
- FSM:
  - IDLE: commit_req=1 → COMMIT_WAIT.
    - cfg_valid and commit_req in the same cycle: the write is applied and included in the commit.
  - COMMIT_WAIT: busy=1.
    - The sample on the sample_en=1 cycle is still processed with the old coefficients.
    - Next state is SWAP.
    - Waits indefinitely without sample_en.
  - SWAP: exactly 1 cycle.
    - Active bank <= shadow bank; stage_clr=1; bypass=1; filt_enable=0.
    - A sample_en during SWAP is dropped and not counted.
    - Next state: SETTLE if SETTLE_SAMPLES>0, else IDLE with commit_ack.
  - SETTLE: bypass=1.
    - Counts sample_en strobes.
    - On the strobe that makes count==SETTLE_SAMPLES, go to IDLE; counter cleared.
  - Entering IDLE from SWAP or SETTLE: commit_ack=1 for exactly one cycle; bypass=0 from the IDLE cycle onward.
- commit_req is ignored in COMMIT_WAIT, SWAP and SETTLE; there is no pending-request latch.
- coef_out, stage_clr, bypass, commit_ack and cfg_err are registered outputs.
- The new coef_out value is visible in the cycle after SWAP, i.e. coincident with stage_clr deasserting.
- Latency, commit_req to commit_ack: 1 cycle + time until the next sample_en + 1 SWAP cycle + SETTLE_SAMPLES strobes.

Test Plan:
- Reset then idle → coef_out==COEF_RST, cfg_ready=1, bypass=0; filt_enable mirrors sample_en.
- Write stage1/sel3 = 16'hc200, no commit, 10 samples → coef_out unchanged (stage1 a1 still 16'hc1ec). Then commit with sample_en every 4 cycles → stage_clr pulses once; coef_out stage1 a1 = 16'hc200; bypass high for exactly 4 strobes; commit_ack one cycle after the 4th strobe.
- cfg_stage=2 (NUM_STAGES=2) or cfg_sel=5 → cfg_err one-cycle pulse; coef_out and shadow bank unchanged (verified via a subsequent commit).
- cfg_valid with commit_req in the same cycle → the written value appears in coef_out after SWAP. Writes during COMMIT_WAIT/SETTLE → cfg_ready=0; the values are never applied.
- rst asserted during SETTLE → next cycle: IDLE, bypass=0, no commit_ack, coef_out==COEF_RST.
- SETTLE_SAMPLES=0 build: commit → SWAP then IDLE; commit_ack one cycle after stage_clr; bypass high for the SWAP cycle only.
